level0_control: RTL and testbench

- Level-0 controller of the accelerator.
- On a start command for level 0, it loads four 64-bit working registers from the host data bus, then pulses a start to the 16-lane search unit.
- While running, it arbitrates search-unit write requests round-robin into a single result queue and grants one write per cycle while the queue is not full.
- A stop request halts the search unit and returns the block to idle.

---
 rtl/level0_control.sv | 114 +++++++++++
 tb/tb_level0_control.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/level0_control.sv
// Level-0 controller: loads four working registers from the host bus, starts the
// search unit, then round-robin arbitrates its lane write requests into one result queue.
module level0_control #(
  parameter int NLANES = 16,
  parameter int DW     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop,
  output logic              stopSU,
  input  logic [DW-1:0]     dataToLC,
  input  logic              startLC,
  input  logic [2:0]        levels,
  output logic [3:0]        regEn,
  output logic [DW-1:0]     dataToReg,
  output logic              startSU,
  input  logic [NLANES-1:0] writeReq,
  output logic [4:0]        writeQen,
  output logic              enableQ,
  output logic              incrPC,
  input  logic              Qfull,
  output logic [NLANES-1:0] writeSucceeded
);

  localparam int PW = $clog2(NLANES);

  typedef enum logic [3:0] {
    IDLE, LOAD0, LOAD1, LOAD2, LOAD3, START, RUN, HALT
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] rr_ptr;
  logic          grant_found;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] lane;
  logic [NLANES-1:0] grant_onehot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= '1;
    end else begin
      state <= state_next;
      if (state == RUN && grant_found) rr_ptr <= grant_idx;
    end
  end

  // Scan from the lane after the last winner; an offset of NLANES wraps back onto rr_ptr itself.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    lane        = '0;
    if (state == RUN && !Qfull) begin
      for (int i = 1; i <= NLANES; i++) begin
        lane = rr_ptr + PW'(i);
        if (!grant_found && writeReq[lane]) begin
          grant_found = 1'b1;
          grant_idx   = lane;
        end
      end
    end
  end

  assign grant_onehot = grant_found ? (NLANES'(1) << grant_idx) : '0;

  always_comb begin
    state_next = state;
    if (state != IDLE && stop) begin
      state_next = HALT;
    end else begin
      case (state)
        IDLE:    if (startLC && levels == 3'b000) state_next = LOAD0;
        LOAD0:   state_next = LOAD1;
        LOAD1:   state_next = LOAD2;
        LOAD2:   state_next = LOAD3;
        LOAD3:   state_next = START;
        START:   state_next = RUN;
        RUN:     state_next = RUN;
        HALT:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    regEn          = 4'b0000;
    dataToReg      = '0;
    startSU        = 1'b0;
    stopSU         = 1'b0;
    writeQen       = 5'b00000;
    enableQ        = 1'b0;
    incrPC         = 1'b0;
    writeSucceeded = '0;
    case (state)
      LOAD0: begin regEn = 4'b0001; dataToReg = dataToLC; end
      LOAD1: begin regEn = 4'b0010; dataToReg = dataToLC; end
      LOAD2: begin regEn = 4'b0100; dataToReg = dataToLC; end
      LOAD3: begin regEn = 4'b1000; dataToReg = dataToLC; end
      START: startSU = 1'b1;
      HALT:  stopSU  = 1'b1;
      RUN: begin
        if (grant_found) begin
          writeSucceeded = grant_onehot;
          writeQen       = {1'b1, grant_idx};
          enableQ        = 1'b1;
        end
        // Any request left unserved stalls the search units for this cycle.
        incrPC = ((writeReq & ~grant_onehot) == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_level0_control.sv
// Scoreboard bench for level0_control: a behavioural model pushes expected outputs
// per driven cycle, which are popped and compared mid-cycle.
module tb_level0_control;

  logic        clk;
  logic        rst;
  logic        stop;
  logic        stopSU;
  logic [63:0] dataToLC;
  logic        startLC;
  logic [2:0]  levels;
  logic [3:0]  regEn;
  logic [63:0] dataToReg;
  logic        startSU;
  logic [15:0] writeReq;
  logic [4:0]  writeQen;
  logic        enableQ;
  logic        incrPC;
  logic        Qfull;
  logic [15:0] writeSucceeded;

  level0_control dut (
    .clk(clk), .rst(rst), .stop(stop), .stopSU(stopSU),
    .dataToLC(dataToLC), .startLC(startLC), .levels(levels),
    .regEn(regEn), .dataToReg(dataToReg), .startSU(startSU),
    .writeReq(writeReq), .writeQen(writeQen), .enableQ(enableQ),
    .incrPC(incrPC), .Qfull(Qfull), .writeSucceeded(writeSucceeded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  reg_en;
    logic [63:0] data;
    logic        start_su;
    logic        stop_su;
    logic [15:0] ws;
    logic [4:0]  wq;
    logic        enq;
    logic        incr;
  } exp_t;

  exp_t sb[$];
  int assertCount = 0;
  int failCount   = 0;

  // Model state: 0 idle, 1..4 load0..3, 5 start, 6 run, 7 halt.
  int mstate = 0;
  int mptr   = 15;

  localparam logic [63:0] LOAD_DATA = 64'hFFF0F0F0F0F0F0FF;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic start_v, input logic [2:0] lv,
                               input logic [63:0] data, input logic [15:0] req,
                               input logic qfull_v, input logic stop_v);
    exp_t e;
    exp_t got;
    int   win;
    int   ns;
    @(posedge clk);
    #1;
    rst = rst_v; startLC = start_v; levels = lv; dataToLC = data;
    writeReq = req; Qfull = qfull_v; stop = stop_v;

    if (!rst_v) begin
      mstate = 0;
      mptr   = 15;
    end
    e.reg_en = 4'b0; e.data = 64'h0; e.start_su = 1'b0; e.stop_su = 1'b0;
    e.ws = 16'h0; e.wq = 5'h0; e.enq = 1'b0; e.incr = 1'b0;
    win = -1;
    if (mstate >= 1 && mstate <= 4) begin
      e.reg_en = 4'(1 << (mstate - 1));
      e.data   = data;
    end
    e.start_su = (mstate == 5);
    e.stop_su  = (mstate == 7);
    if (mstate == 6) begin
      if (!qfull_v) begin
        for (int k = 1; k <= 16; k++) begin
          int ln;
          ln = (mptr + k) % 16;
          if (win < 0 && req[ln]) win = ln;
        end
      end
      if (win >= 0) begin
        e.ws  = 16'(1 << win);
        e.wq  = 5'(16 + win);
        e.enq = 1'b1;
      end
      e.incr = ((req & ~e.ws) == 16'h0);
    end
    sb.push_back(e);

    @(negedge clk);
    got = sb.pop_front();
    checkOutput("regEn",          64'(regEn),          64'(got.reg_en));
    checkOutput("dataToReg",      dataToReg,           got.data);
    checkOutput("startSU",        64'(startSU),        64'(got.start_su));
    checkOutput("stopSU",         64'(stopSU),         64'(got.stop_su));
    checkOutput("writeSucceeded", 64'(writeSucceeded), 64'(got.ws));
    checkOutput("writeQen",       64'(writeQen),       64'(got.wq));
    checkOutput("enableQ",        64'(enableQ),        64'(got.enq));
    checkOutput("incrPC",         64'(incrPC),         64'(got.incr));

    if (rst_v) begin
      if (mstate != 0 && stop_v) ns = 7;
      else begin
        case (mstate)
          0:       ns = (start_v && lv == 3'b000) ? 1 : 0;
          5:       ns = 6;
          6:       ns = 6;
          7:       ns = 0;
          default: ns = mstate + 1;
        endcase
      end
      if (mstate == 6 && win >= 0) mptr = win;
      mstate = ns;
    end
  endtask

  initial begin
    rst = 1'b0; stop = 1'b0; startLC = 1'b0; levels = 3'b000;
    dataToLC = 64'h0; writeReq = 16'h0; Qfull = 1'b0;

    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 3'b000, 64'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 3'b001, LOAD_DATA, 16'h0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 3'b000, LOAD_DATA, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 3'b000, LOAD_DATA, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'h0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'h0001, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'h8000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'h8001, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'h0020, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'h0020, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++)
      applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'($urandom), ($urandom_range(0, 3) == 0), 1'b0);

    applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'h0500, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'h0500, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'h0500, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'h0500, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'h0, 1'b0, 1'b1);

    // Restart with startLC held high through the loads; it must not disturb the sequence.
    applyStimulus(1'b1, 1'b1, 3'b000, 64'h0123456789ABCDEF, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 3'b000, 64'({$urandom, $urandom}), 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'($urandom), ($urandom_range(0, 4) == 0), 1'b0);

    applyStimulus(1'b0, 1'b0, 3'b000, 64'h0, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 64'h0, 16'hFFFF, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
